// File: rtl/sdvig_out.sv
// sdvig_out: parallel-in, serial-out register, MSB first.
// Loads sw on a load push. Shifts on a manual push or on a timed tick.
//
// Ports:
//   clk       system clock (rising edge)
//   rst       asynchronous active-high reset
//   key_load  raw load button
//   key_shift raw shift button (manual mode only)
//   sw        parallel word sampled on load
//   sw_auto   1 = timed shifting, 0 = manual shifting
//   bit_out   last bit shifted out, held until the next shift
//   bit_valid one-cycle pulse when bit_out updates
//   LEDS      current shift register contents
//   count     bits still to send
//   empty     high when count == 0
module sdvig_out #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_load,
    input  logic                       key_shift,
    input  logic [WIDTH-1:0]           sw,
    input  logic                       sw_auto,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic [WIDTH-1:0]           LEDS,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TICK_DIV);

    logic [2:0]       load_sync;
    logic [2:0]       shift_sync;
    logic             push_load;
    logic             push_shift;
    logic             auto_q;
    logic             mode_chg;
    logic [TW-1:0]    tick;
    logic             tick_hit;
    logic             busy;
    logic             shift_ev;
    logic             do_shift;
    logic [WIDTH-1:0] sreg;

    // Three-flop chains: bit0 is the sampler, push fires on a 0->1 seen
    // between bit1 and bit2. No debounce, so bounces give extra pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_sync  <= '0;
            shift_sync <= '0;
            auto_q     <= 1'b0;
        end else begin
            load_sync  <= {load_sync[1:0], key_load};
            shift_sync <= {shift_sync[1:0], key_shift};
            auto_q     <= sw_auto;
        end
    end

    assign push_load  = load_sync[1] & ~load_sync[2];
    assign push_shift = shift_sync[1] & ~shift_sync[2];

    // A mode flip restarts the tick period so the remaining bits simply
    // continue under the new mode.
    assign mode_chg = sw_auto ^ auto_q;
    assign busy     = (count != '0);

    assign tick_hit = sw_auto & ~mode_chg & busy
                    & (tick == TW'(TICK_DIV - 1));

    always_comb begin
        shift_ev = push_shift;
        if (sw_auto) begin
            shift_ev = tick_hit;
        end
    end

    // Load has priority; a shift with nothing left is dropped.
    assign do_shift = shift_ev & busy & ~push_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (push_load | mode_chg | ~sw_auto | ~busy | tick_hit) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            count   <= '0;
            bit_out <= 1'b0;
        end else if (push_load) begin
            sreg  <= sw;
            count <= CW'(WIDTH);
        end else if (do_shift) begin
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
            count   <= count - CW'(1);
            bit_out <= sreg[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= do_shift;
        end
    end

    assign LEDS  = sreg;
    assign empty = ~busy;

endmodule

// File: doc/sdvig_out.md
Name: sdvig_out

Overview:
Parallel-in, serial-out companion to the button-driven shift-in register. It loads a WIDTH-bit word from switches on a button press, then emits it MSB-first one bit per shift event. Shift events come from a second button (manual) or a divided-clock tick (auto). Bit order is chosen so a shift-in receiver (shift left, new bit into LSB) fed with bit_out on each bit_valid reconstructs the loaded word after WIDTH shifts.

Parameters:
WIDTH, 8, word length in bits (>=2)
TICK_DIV, 50000000, auto-mode shift period in clk cycles (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
key_load  input  1  raw load button, asynchronous to clk
key_shift  input  1  raw shift button, asynchronous to clk
sw  input  WIDTH  parallel data word, sampled on load
sw_auto  input  1  1 = timed auto-shift, 0 = manual shift via key_shift
bit_out  output  1  last bit shifted out, held until next shift
bit_valid  output  1  one-cycle pulse, same cycle bit_out updates
LEDS  output  WIDTH  current shift register contents
count  output  $clog2(WIDTH+1)  bits remaining to send
empty  output  1  high when count == 0

Behaviour:
- Reset (async, any time, including mid-word): sreg=0, count=0, bit_out=0, bit_valid=0, tick counter=0, edge-detect flops=0, empty=1. Release is synchronous to clk.
- Edge detect, per key: chain k1<=key, k2<=k1, k3<=k2; push = k2 & ~k3.
  - Exactly one-cycle pulse per rising edge.
  - Push is high during the 3rd clk edge after the key rises and acts on that edge.
  - Holding the key gives no repeats. No debounce; bounces give extra pushes by design.
- Load (push_load): sreg<=sw, count<=WIDTH, tick<=0. bit_out unchanged; bit_valid=0 that cycle.
- Shift event when count>0:
  - bit_out<=sreg[WIDTH-1], sreg<=sreg<<1 (LSB filled 0), count<=count-1, bit_valid<=1 for one cycle.
  - Registered outputs: bit_out and bit_valid appear the cycle after the shift event is sampled.
- Shift event when count==0: ignored. sreg, count and bit_out are unchanged; no bit_valid.
- Manual mode (sw_auto=0): a shift event is push_shift. Tick counter is held at 0.
- Auto mode (sw_auto=1):
  - push_shift is ignored.
  - While count>0, the tick counter increments each cycle. At TICK_DIV-1 it wraps to 0 and produces the shift event.
  - While count==0, the tick counter is held at 0.
  - Result: the first auto bit follows TICK_DIV cycles after a load.
- sw_auto toggling mid-word: the tick counter clears on any change. The remaining bits continue in the new mode, and no bit is lost or duplicated.
- Simultaneous load and shift event in the same cycle: load wins, the shift is discarded, and count=WIDTH.
- Load while count>0: the word in progress is abandoned and the new word starts.
- empty is combinational from count. LEDS = sreg.
- After WIDTH shifts: sreg==0, count==0, empty=1.

Test Plan:
- Reset mid-operation: load 8'hA5, shift 3 times, assert rst for 1 cycle -> LEDS=0, count=0, empty=1, bit_out=0, with no clk edge required.
- Manual shift: load sw=8'hB4, then 8 key_shift presses -> bit_out sequence 1,0,1,1,0,1,0,0; exactly 8 bit_valid pulses; then empty=1.
- Loopback: feed bit_out/bit_valid into a reference shift-in model for a sweep of sw values (00, FF, 5A, 81, random) -> received byte equals sw each time.
- Overrun and hold: 10 shift presses after a load -> only 8 bit_valid; bit_out stays at the last bit; a key held high for 100 cycles -> single pulse.
- Auto mode with TICK_DIV=4: sw_auto=1, load 8'hC3 -> bit_valid every 4 cycles, first one 4 cycles after the load edge; 8 pulses total; key_shift presses ignored.
- Conflicts: push_load and shift in the same cycle -> count=8, no bit_valid. Reload after 5 bits -> count=8 and the new word is sent from its MSB.
